// File: rtl/data_mem_responder_pkg.sv
// mem_pkg: shared types and constants for the data-memory responder.
// Holds the responder FSM state encoding and the MemWrite control-word bit
// positions, which the processor control unit also uses.
package mem_pkg;

    // MemWrite = {Byte, we}
    localparam int MEMW_WE_BIT   = 0;
    localparam int MEMW_BYTE_BIT = 1;

    localparam int BYTE_LANES = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_WORD,
        RD_ISSUE,
        RD_DATA,
        RMW_WRITE
    } mem_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: core-side data-memory request/response bundle.
// master = processor (drives req_valid/MemWrite/addr/wdata),
// slave  = responder (drives stall/resp_valid/rdata/addr_err/align_err).
interface data_mem_responder_if;
    logic        req_valid;
    logic [1:0]  MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        addr_err;
    logic        align_err;

    modport master (
        output req_valid, MemWrite, addr, wdata,
        input  stall, resp_valid, rdata, addr_err, align_err
    );

    modport slave (
        input  req_valid, MemWrite, addr, wdata,
        output stall, resp_valid, rdata, addr_err, align_err
    );
endinterface

// File: rtl/data_mem_responder_byte_lane_unit.sv
// byte_lane_unit: combinational byte-lane extract (loads) and merge (stores).
// Ports: word_i/offset_i/byte_i in; lane_o = word_i lane offset_i,
//        merged_o = word_i with lane offset_i replaced by byte_i. Little-endian.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [7:0]  byte_i,
    output logic [7:0]  lane_o,
    output logic [31:0] merged_o
);
    always_comb begin
        lane_o   = '0;
        merged_o = word_i;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (offset_i == i[1:0]) begin
                lane_o             = word_i[8*i +: 8];
                merged_o[8*i +: 8] = byte_i;
            end
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: services word/byte loads and stores from the core
// against a word-wide RAM with no byte enables and 1-cycle read latency.
// Ports: clk/rst; bus (core side, slave modport); ram_addr/ram_we/ram_wdata out,
//        ram_rdata in. Latency: word store 1, load and byte store (RMW) 2.
// Backpressure: stall = req_valid & ~resp_valid; one access in flight at a time.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);
    // First byte-address bit beyond the RAM.
    localparam int HI_LSB = ADDR_WIDTH + 2;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("data_mem_responder: DATA_WIDTH must be 32");
    end

    mem_state_t            state_q;
    logic [1:0]            memw_q;
    logic [31:0]           wdata_q;
    logic [1:0]            offset_q;
    logic                  range_err_q;
    logic                  align_err_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic                  ram_we_q;
    logic                  resp_valid_q;

    logic                  req_we_d;
    logic                  req_byte_d;
    logic                  range_err_d;
    logic                  align_err_d;
    logic [7:0]            lane;
    logic [31:0]           merged;

    assign req_we_d    = bus.MemWrite[MEMW_WE_BIT];
    assign req_byte_d  = bus.MemWrite[MEMW_BYTE_BIT];
    assign range_err_d = |bus.addr[31:HI_LSB];
    assign align_err_d = ~req_byte_d & (|bus.addr[1:0]);

    // ram_rdata carries the word read in RD_ISSUE during both RD_DATA and
    // RMW_WRITE, so the same unit serves the load extract and the RMW merge.
    byte_lane_unit u_lane (
        .word_i   (ram_rdata),
        .offset_i (offset_q),
        .byte_i   (wdata_q[7:0]),
        .lane_o   (lane),
        .merged_o (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            memw_q       <= '0;
            wdata_q      <= '0;
            offset_q     <= '0;
            range_err_q  <= 1'b0;
            align_err_q  <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            ram_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        memw_q      <= bus.MemWrite;
                        wdata_q     <= bus.wdata;
                        offset_q    <= bus.addr[1:0];
                        range_err_q <= range_err_d;
                        align_err_q <= align_err_d;
                        ram_addr_q  <= bus.addr[HI_LSB-1:2];
                        if (req_we_d && !req_byte_d) begin
                            // Word store completes in the next cycle.
                            state_q      <= WR_WORD;
                            ram_we_q     <= ~range_err_d;
                            resp_valid_q <= 1'b1;
                        end else begin
                            // Loads and byte stores both need the old word.
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    resp_valid_q <= 1'b1;
                    if (memw_q[MEMW_WE_BIT]) begin
                        state_q  <= RMW_WRITE;
                        ram_we_q <= ~range_err_q;
                    end else begin
                        state_q <= RD_DATA;
                    end
                end
                WR_WORD, RD_DATA, RMW_WRITE: state_q <= IDLE;
                default:                     state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall      = bus.req_valid & ~resp_valid_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.addr_err   = resp_valid_q & range_err_q;
    assign bus.align_err  = resp_valid_q & align_err_q;
    assign bus.rdata      = (resp_valid_q && state_q == RD_DATA && !range_err_q)
                          ? (memw_q[MEMW_BYTE_BIT] ? {24'b0, lane} : ram_rdata)
                          : '0;

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = (state_q == RMW_WRITE) ? merged : wdata_q;

endmodule
